// File: rtl/dmem_access_unit_pkg.sv
// Shared types for the LC-3b memory-stage access engine.
// Holds the operation and FSM state encodings plus small op classifiers.
package dmem_access_unit_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    NONE,
    LDW,
    LDB,
    STW,
    STB,
    LDI,
    STI
  } lc3b_mem_op;

  typedef enum logic [1:0] {
    IDLE,
    PTR,
    ACCESS,
    DONE
  } dmem_state_e;

  function automatic logic op_is_indirect(lc3b_mem_op op);
    return (op == LDI) || (op == STI);
  endfunction

  function automatic logic op_is_write(lc3b_mem_op op);
    return (op == STW) || (op == STB) || (op == STI);
  endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Pipeline request/response and data-memory bus of the access unit.
// slave is the access unit; master is the pipeline plus memory side.
interface dmem_access_unit_if #(
  parameter int LINE_WIDTH = 128
);
  import dmem_access_unit_pkg::*;

  logic                    req_valid;
  lc3b_mem_op              req_op;
  logic [15:0]             req_addr;
  logic [15:0]             req_wdata;
  logic                    stall;
  logic                    done;
  logic [15:0]             rdata;
  logic                    dmem_read;
  logic                    dmem_write;
  logic [15:0]             dmem_address;
  logic [LINE_WIDTH-1:0]   dmem_wdata;
  logic [LINE_WIDTH/8-1:0] dmem_byte_enable;
  logic [LINE_WIDTH-1:0]   dmem_rdata;
  logic                    dmem_resp;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, dmem_rdata, dmem_resp,
    output stall, done, rdata, dmem_read, dmem_write, dmem_address,
           dmem_wdata, dmem_byte_enable
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, dmem_rdata, dmem_resp,
    input  stall, done, rdata, dmem_read, dmem_write, dmem_address,
           dmem_wdata, dmem_byte_enable
  );

endinterface

// File: rtl/line_word_select.sv
// Picks one 16-bit word out of a memory line by word index.
// Shared by the pointer fetch and the load return path.
module line_word_select #(
  parameter  int LINE_WIDTH = 128,
  localparam int IDX_BITS   = $clog2(LINE_WIDTH / 16)
) (
  input  logic [LINE_WIDTH-1:0] line_i,
  input  logic [IDX_BITS-1:0]   idx_i,
  output logic [15:0]           word_o
);

  assign word_o = line_i[idx_i*16 +: 16];

endmodule

// File: rtl/dmem_access_unit.sv
// LC-3b memory-stage access engine: one or two line accesses per request,
// with word/byte lane selection, byte enables and LDB sign extension.
//
// state  | meaning
// IDLE   | waiting for a non-NONE request; latches it on acceptance
// PTR    | reading the LDI/STI pointer word
// ACCESS | performing the data read or write
// DONE   | one-cycle completion pulse
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int LINE_WIDTH = 128,
  parameter int OFF_BITS   = $clog2(LINE_WIDTH / 8)
) (
  input  logic               clk,
  input  logic               reset,
  dmem_access_unit_if.slave  bus
);

  localparam int NUM_BYTES = LINE_WIDTH / 8;
  localparam int NUM_WORDS = LINE_WIDTH / 16;

  dmem_state_e             state_q, state_d;
  lc3b_mem_op              op_q, op_d;
  logic [15:0]             addr_q, addr_d;
  logic [15:0]             wdata_q, wdata_d;
  logic [15:0]             ptr_q, ptr_d;
  logic [15:0]             rdata_q, rdata_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic [15:0]             maddr_q, maddr_d;
  logic [LINE_WIDTH-1:0]   mwdata_q, mwdata_d;
  logic [NUM_BYTES-1:0]    be_q, be_d;

  logic [15:0]             target;
  logic [OFF_BITS-2:0]     word_idx;
  logic [15:0]             word_sel;
  logic [7:0]              byte_sel;
  logic                    resp_ok;
  logic                    req_take;

  assign target   = op_is_indirect(op_q) ? ptr_q : addr_q;
  assign word_idx = (state_q == PTR) ? addr_q[OFF_BITS-1:1] : target[OFF_BITS-1:1];
  assign byte_sel = target[0] ? word_sel[15:8] : word_sel[7:0];
  // A response only counts while one of our strobes is up; stray ones are dropped.
  assign resp_ok  = bus.dmem_resp && (rd_q || wr_q);
  assign req_take = bus.req_valid && (bus.req_op != NONE);

  line_word_select #(
    .LINE_WIDTH (LINE_WIDTH)
  ) u_word_sel (
    .line_i (bus.dmem_rdata),
    .idx_i  (word_idx),
    .word_o (word_sel)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ptr_d    = ptr_q;
    rdata_d  = rdata_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    be_d     = be_q;

    unique case (state_q)
      IDLE: begin
        if (req_take) begin
          op_d    = bus.req_op;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          state_d = op_is_indirect(bus.req_op) ? PTR : ACCESS;
        end
      end

      PTR: begin
        if (resp_ok) begin
          ptr_d   = word_sel;
          rd_d    = 1'b0;
          state_d = ACCESS;
        end else begin
          rd_d    = 1'b1;
          maddr_d = {addr_q[15:1], 1'b0};
          be_d    = '1;
        end
      end

      ACCESS: begin
        if (resp_ok) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = DONE;
          if (!op_is_write(op_q)) begin
            rdata_d = (op_q == LDB) ? {{8{byte_sel[7]}}, byte_sel} : word_sel;
          end
        end else begin
          maddr_d = {target[15:1], 1'b0};
          if (op_is_write(op_q)) begin
            wr_d = 1'b1;
            if (op_q == STB) begin
              mwdata_d = {NUM_BYTES{wdata_q[7:0]}};
              be_d     = {{(NUM_BYTES-1){1'b0}}, 1'b1} << target[OFF_BITS-1:0];
            end else begin
              mwdata_d = {NUM_WORDS{wdata_q}};
              be_d     = {{(NUM_BYTES-2){1'b0}}, 2'b11} << {target[OFF_BITS-1:1], 1'b0};
            end
          end else begin
            rd_d = 1'b1;
            be_d = '1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= NONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      ptr_q    <= '0;
      rdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      be_q     <= '1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ptr_q    <= ptr_d;
      rdata_q  <= rdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      be_q     <= be_d;
    end
  end

  assign bus.stall            = (state_q == PTR) || (state_q == ACCESS) ||
                                ((state_q == IDLE) && req_take);
  assign bus.done             = (state_q == DONE);
  assign bus.rdata            = rdata_q;
  assign bus.dmem_read        = rd_q;
  assign bus.dmem_write       = wr_q;
  assign bus.dmem_address     = maddr_q;
  assign bus.dmem_wdata       = mwdata_q;
  assign bus.dmem_byte_enable = be_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: 128- and 256-bit instances run the same requests
// against byte-addressed memories and a byte-level reference model.
module tb_dmem_access_unit;
  import dmem_access_unit_pkg::*;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  dmem_access_unit_if #(.LINE_WIDTH(128)) if_a ();
  dmem_access_unit_if #(.LINE_WIDTH(256)) if_b ();

  dmem_access_unit #(.LINE_WIDTH(128)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  dmem_access_unit #(.LINE_WIDTH(256)) dut_b (.clk(clk), .reset(reset), .bus(if_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit [7:0]     mem_a   [0:65535];
  bit [7:0]     mem_b   [0:65535];
  bit [7:0]     ref_mem [0:65535];
  int           mem_delay = 1;
  bit           stray = 1'b0;
  int           cnt_a = 0, cnt_b = 0;
  int           log_addr_a[$], log_addr_b[$];
  bit           log_wr_a[$], log_wr_b[$];
  logic [255:0] last_be_a, last_be_b, last_wd_a, last_wd_b;
  logic [15:0]  exp_rdata = 16'h0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory models: respond on the mem_delay-th cycle a strobe is visible.
  always @(posedge clk) begin
    int base;
    logic [255:0] line;
    #1;
    if (if_a.dmem_read || if_a.dmem_write) begin
      cnt_a++;
      if (cnt_a == mem_delay) begin
        base = int'(if_a.dmem_address) & ~15;
        line = '0;
        for (int i = 0; i < 16; i++) line[8*i +: 8] = mem_a[base+i];
        if (if_a.dmem_write)
          for (int i = 0; i < 16; i++)
            if (if_a.dmem_byte_enable[i]) mem_a[base+i] = if_a.dmem_wdata[8*i +: 8];
        log_addr_a.push_back(int'(if_a.dmem_address));
        log_wr_a.push_back(if_a.dmem_write);
        last_be_a = 256'(if_a.dmem_byte_enable);
        last_wd_a = 256'(if_a.dmem_wdata);
        if_a.dmem_rdata = line[127:0];
        if_a.dmem_resp  = 1'b1;
      end else if_a.dmem_resp = 1'b0;
    end else begin
      cnt_a = 0;
      if_a.dmem_resp = 1'b0;
    end
    if (if_b.dmem_read || if_b.dmem_write) begin
      cnt_b++;
      if (cnt_b == mem_delay) begin
        base = int'(if_b.dmem_address) & ~31;
        for (int i = 0; i < 32; i++) line[8*i +: 8] = mem_b[base+i];
        if (if_b.dmem_write)
          for (int i = 0; i < 32; i++)
            if (if_b.dmem_byte_enable[i]) mem_b[base+i] = if_b.dmem_wdata[8*i +: 8];
        log_addr_b.push_back(int'(if_b.dmem_address));
        log_wr_b.push_back(if_b.dmem_write);
        last_be_b = 256'(if_b.dmem_byte_enable);
        last_wd_b = if_b.dmem_wdata;
        if_b.dmem_rdata = line;
        if_b.dmem_resp  = 1'b1;
      end else if_b.dmem_resp = 1'b0;
    end else begin
      cnt_b = 0;
      if_b.dmem_resp = 1'b0;
    end
    if (stray) begin
      if_a.dmem_resp = 1'b1;
      if_b.dmem_resp = 1'b1;
      stray = 1'b0;
    end
  end

  function automatic logic [15:0] ref_word(input int a);
    int w = a & 32'hFFFE;
    return {ref_mem[w+1], ref_mem[w]};
  endfunction

  task automatic set_word(input int a, input logic [15:0] w);
    int b = a & 32'hFFFE;
    {ref_mem[b+1], ref_mem[b]} = w;
    {mem_a[b+1], mem_a[b]} = w;
    {mem_b[b+1], mem_b[b]} = w;
  endtask

  // Byte-memory semantics of each operation.
  task automatic model_op(input lc3b_mem_op op, input int a, input logic [15:0] wd);
    int p;
    case (op)
      LDW: exp_rdata = ref_word(a);
      LDB: exp_rdata = {{8{ref_mem[a][7]}}, ref_mem[a]};
      LDI: exp_rdata = ref_word(int'(ref_word(a)));
      STW: begin p = a & 32'hFFFE; {ref_mem[p+1], ref_mem[p]} = wd; end
      STB: ref_mem[a] = wd[7:0];
      STI: begin p = int'(ref_word(a)) & 32'hFFFE; {ref_mem[p+1], ref_mem[p]} = wd; end
      default: ;
    endcase
  endtask

  task automatic drive(input bit v, input lc3b_mem_op op, input int a, input logic [15:0] wd);
    if_a.req_valid = v; if_a.req_op = op; if_a.req_addr = 16'(a); if_a.req_wdata = wd;
    if_b.req_valid = v; if_b.req_op = op; if_b.req_addr = 16'(a); if_b.req_wdata = wd;
  endtask

  task automatic run_op(input string tag, input lc3b_mem_op op, input int a,
                        input logic [15:0] wd, input int d);
    int ka = -1, kb = -1, sa = 0, sb = 0, exp_lat;
    mem_delay = d;
    log_addr_a.delete(); log_addr_b.delete(); log_wr_a.delete(); log_wr_b.delete();
    @(posedge clk); #1;
    drive(1'b1, op, a, wd);
    model_op(op, a, wd);
    exp_lat = (op == LDI || op == STI) ? 3 + 2*d : 2 + d;
    for (int k = 0; k < 60 && (ka < 0 || kb < 0); k++) begin
      @(negedge clk);
      if (ka < 0) begin
        if (if_a.done) begin ka = k; if_a.req_valid = 1'b0; if (if_a.stall) sa++; end
        else if (!if_a.stall) sa++;
      end
      if (kb < 0) begin
        if (if_b.done) begin kb = k; if_b.req_valid = 1'b0; if (if_b.stall) sb++; end
        else if (!if_b.stall) sb++;
      end
    end
    drive(1'b0, NONE, 0, 16'h0);
    check({tag, "_lat_a"}, 256'(ka), 256'(exp_lat));
    check({tag, "_lat_b"}, 256'(kb), 256'(exp_lat));
    check({tag, "_stall_a"}, 256'(sa), 256'd0);
    check({tag, "_stall_b"}, 256'(sb), 256'd0);
    check({tag, "_rdata_a"}, 256'(if_a.rdata), 256'(exp_rdata));
    check({tag, "_rdata_b"}, 256'(if_b.rdata), 256'(exp_rdata));
    @(negedge clk);
    check({tag, "_pulse_a"}, 256'(if_a.done), 256'd0);
    check({tag, "_pulse_b"}, 256'(if_b.done), 256'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, diffs;
    logic [255:0] one;
    reset = 1'b1;
    drive(1'b0, NONE, 0, 16'h0);
    if_a.dmem_resp = 1'b0; if_a.dmem_rdata = '0;
    if_b.dmem_resp = 1'b0; if_b.dmem_rdata = '0;
    set_word(16'h100A, 16'hBEEF);
    set_word(16'h2002, 16'h80FF);
    set_word(16'h4000, 16'h5006);
    set_word(16'h101E, 16'hC3A5);
    set_word(16'h5006, 16'h7777);
    for (int i = 16'h6000; i < 16'h6100; i += 2) set_word(i, {8'h60, 8'($urandom)});

    repeat (3) @(negedge clk);
    check("rst_stall_a", 256'(if_a.stall), 256'd0);
    check("rst_done_b",  256'(if_b.done), 256'd0);
    check("rst_read_a",  256'(if_a.dmem_read), 256'd0);
    check("rst_write_b", 256'(if_b.dmem_write), 256'd0);
    check("rst_rdata_a", 256'(if_a.rdata), 256'd0);
    check("rst_addr_b",  256'(if_b.dmem_address), 256'd0);
    check("rst_be_a",    256'(if_a.dmem_byte_enable), 256'hFFFF);
    check("rst_be_b",    256'(if_b.dmem_byte_enable), 256'hFFFF_FFFF);
    check("rst_wd_b",    if_b.dmem_wdata, 256'd0);
    reset = 1'b0;

    run_op("ldw", LDW, 16'h100A, 16'h0, 1);
    check("ldw_const_a", 256'(if_a.rdata), 256'hBEEF);
    check("ldw_addr_a", 256'(log_addr_a[0]), 256'h100A);
    run_op("ldb_hi", LDB, 16'h2003, 16'h0, 1);
    check("ldb_hi_const_b", 256'(if_b.rdata), 256'hFF80);
    run_op("ldb_lo", LDB, 16'h2002, 16'h0, 2);
    check("ldb_lo_const_a", 256'(if_a.rdata), 256'hFFFF);

    run_op("stb", STB, 16'h3005, 16'h12AB, 1);
    check("stb_be_a", last_be_a, 256'h0020);
    check("stb_be_b", last_be_b, 256'h0020);
    check("stb_wd_a", last_wd_a, {128'h0, {16{8'hAB}}});
    check("stb_wd_b", last_wd_b, {32{8'hAB}});

    run_op("sti", STI, 16'h4000, 16'h1234, 1);
    check("sti_nacc_a", 256'(log_addr_a.size()), 256'd2);
    check("sti_rd_addr_a", 256'(log_addr_a[0]), 256'h4000);
    check("sti_wr_addr_a", 256'(log_addr_a[1]), 256'h5006);
    check("sti_wr_b", 256'(log_wr_b[1]), 256'd1);
    check("sti_be_a", last_be_a, 256'h00C0);
    check("sti_be_b", last_be_b, 256'h00C0);
    check("sti_wd_a", last_wd_a, {128'h0, {8{16'h1234}}});

    @(posedge clk); #1;
    drive(1'b1, NONE, 16'h100A, 16'h0);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (if_a.stall || if_b.stall || if_a.done || if_b.done || if_a.dmem_read) n++;
    end
    drive(1'b0, NONE, 0, 16'h0);
    check("none_idle", 256'(n), 256'd0);

    // Reset during the third wait cycle of a slow load.
    mem_delay = 5;
    @(posedge clk); #1;
    drive(1'b1, LDW, 16'h100A, 16'h0);
    repeat (4) @(posedge clk);
    #2;
    check("mid_rd_before_a", 256'(if_a.dmem_read), 256'd1);
    check("mid_rd_before_b", 256'(if_b.dmem_read), 256'd1);
    reset = 1'b1;
    #1;
    check("mid_rd_drop_a", 256'(if_a.dmem_read), 256'd0);
    check("mid_rd_drop_b", 256'(if_b.dmem_read), 256'd0);
    drive(1'b0, NONE, 0, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    exp_rdata = 16'h0;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (if_a.done || if_b.done) n++;
    end
    check("mid_no_done", 256'(n), 256'd0);
    stray = 1'b1;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (if_a.done || if_b.done || if_a.dmem_read || if_b.dmem_read || if_a.stall) n++;
    end
    check("stray_ignored", 256'(n), 256'd0);
    check("stray_rdata_a", 256'(if_a.rdata), 256'd0);
    run_op("post_rst", LDW, 16'h100A, 16'h0, 1);

    run_op("ldw_w15", LDW, 16'h101E, 16'h0, 1);
    check("ldw_w15_const_b", 256'(if_b.rdata), 256'hC3A5);
    run_op("stb_l31", STB, 16'h301F, 16'h55CD, 1);
    one = 256'd1;
    check("stb_l31_be_a", last_be_a, one << (16'h301F % 16));
    check("stb_l31_be_b", last_be_b, one << (16'h301F % 32));
    run_op("ldw_mis", LDW, 16'h100B, 16'h0, 1);
    run_op("ldi", LDI, 16'h4000, 16'h0, 2);

    for (int i = 0; i < 30; i++) begin
      run_op("rnd", lc3b_mem_op'($urandom_range(1, 6)), 16'h6000 + int'($urandom_range(0, 255)),
             16'($urandom), int'($urandom_range(1, 3)));
    end

    diffs = 0;
    for (int i = 0; i < 65536; i++) if (mem_a[i] != ref_mem[i]) diffs++;
    check("mem_a_image", 256'(diffs), 256'd0);
    diffs = 0;
    for (int i = 0; i < 65536; i++) if (mem_b[i] != ref_mem[i]) diffs++;
    check("mem_b_image", 256'(diffs), 256'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
